// File: rtl/intellight_axil_pkg.sv
// Shared types and constants for the Intellight AXI4-Lite control register file.
package intellight_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  function automatic logic idx_in_range(input int idx, input int num_regs);
    return (idx >= 0) && (idx < num_regs);
  endfunction

endpackage

// File: rtl/intellight_axil_regs_if.sv
// AXI4-Lite bus between the PS/VIP master and the Intellight register file.
interface intellight_axil_regs_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;

  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/intellight_axil_regs.sv
// AXI4-Lite slave register file driving the Intellight core control registers.
// Independent write (AW/W -> commit -> B) and read (AR -> R) state machines.
module intellight_axil_regs
  import intellight_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  intellight_axil_regs_if.slave               axil,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                 reg_wr_stb
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_t                           wr_state_q;
  rd_state_t                           rd_state_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0]                 wr_stb_q;

  logic                  aw_got_q;
  logic                  w_got_q;
  logic [IDX_W-1:0]      wr_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic [IDX_W-1:0]      ar_idx;
  logic                  wr_in_range;
  logic                  ar_in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_ok;

  assign aw_hs       = axil.AWVALID & awready_q;
  assign w_hs        = axil.WVALID & wready_q;
  assign ar_hs       = axil.ARVALID & arready_q;
  assign ar_idx      = axil.ARADDR[ADDR_WIDTH-1:2];
  assign wr_in_range = idx_in_range(32'(wr_idx_q), NUM_REGS);
  assign ar_in_range = idx_in_range(32'(ar_idx), NUM_REGS);

  // Protection bits and byte offset within a word carry no meaning here.
  assign unused_ok = ^{axil.AWPROT, axil.ARPROT, axil.AWADDR[1:0], axil.ARADDR[1:0]};

  // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_word = regs_q[i];
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= WR_IDLE;
      // NOTE: the register array is reset on purpose: the core must never see undefined control values.
      regs_q     <= '0;
      wr_stb_q   <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      wr_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_stb_q <= '0;
      case (wr_state_q)
        WR_IDLE: begin
          if (aw_hs) begin
            wr_idx_q <= axil.AWADDR[ADDR_WIDTH-1:2];
            aw_got_q <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= axil.WDATA;
            wstrb_q <= axil.WSTRB;
            w_got_q <= 1'b1;
          end
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            wr_state_q <= WR_COMMIT;
          end else begin
            awready_q <= !(aw_got_q || aw_hs);
            wready_q  <= !(w_got_q || w_hs);
          end
        end

        WR_COMMIT: begin
          // Out-of-range indices match no register, so the write is dropped.
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx_q == IDX_W'(i)) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
              end
              wr_stb_q[i] <= 1'b1;
            end
          end
          bresp_q    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
          bvalid_q   <= 1'b1;
          aw_got_q   <= 1'b0;
          w_got_q    <= 1'b0;
          wr_state_q <= WR_RESP;
        end

        WR_RESP: begin
          if (axil.BREADY) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= WR_IDLE;
          end
        end

        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  // Reads sample regs_q before any same-edge commit lands, so they see the old value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            rdata_q    <= rd_word;
            rresp_q    <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= RD_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end

        RD_RESP: begin
          if (axil.RREADY) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
      endcase
    end
  end

  assign axil.AWREADY = awready_q;
  assign axil.WREADY  = wready_q;
  assign axil.BVALID  = bvalid_q;
  assign axil.BRESP   = bresp_q;
  assign axil.ARREADY = arready_q;
  assign axil.RVALID  = rvalid_q;
  assign axil.RDATA   = rdata_q;
  assign axil.RRESP   = rresp_q;

  assign reg_q      = regs_q;
  assign reg_wr_stb = wr_stb_q;

endmodule

// File: tb/tb_intellight_axil_regs.sv
// Bench for intellight_axil_regs: two instances (4 and 3 registers) share one stimulus
// stream and are checked against an array model of the register map.
module tb_intellight_axil_regs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  stb;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0]  awaddr  = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata   = '0;
  logic [3:0]  wstrb   = '0;
  logic        wvalid  = 1'b0;
  logic        bready  = 1'b0;
  logic [3:0]  araddr  = '0;
  logic        arvalid = 1'b0;
  logic        rready  = 1'b0;

  logic [3:0][31:0] reg_q_a;
  logic [3:0]       stb_a;
  logic [2:0][31:0] reg_q_b;
  logic [2:0]       stb_b;

  logic [31:0] mdl [2][4];
  int          nregs [2];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  intellight_axil_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifa ();
  intellight_axil_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifb ();

  assign ifa.AWADDR  = awaddr;  assign ifb.AWADDR  = awaddr;
  assign ifa.AWPROT  = 3'b000;  assign ifb.AWPROT  = 3'b010;
  assign ifa.AWVALID = awvalid; assign ifb.AWVALID = awvalid;
  assign ifa.WDATA   = wdata;   assign ifb.WDATA   = wdata;
  assign ifa.WSTRB   = wstrb;   assign ifb.WSTRB   = wstrb;
  assign ifa.WVALID  = wvalid;  assign ifb.WVALID  = wvalid;
  assign ifa.BREADY  = bready;  assign ifb.BREADY  = bready;
  assign ifa.ARADDR  = araddr;  assign ifb.ARADDR  = araddr;
  assign ifa.ARPROT  = 3'b000;  assign ifb.ARPROT  = 3'b101;
  assign ifa.ARVALID = arvalid; assign ifb.ARVALID = arvalid;
  assign ifa.RREADY  = rready;  assign ifb.RREADY  = rready;

  intellight_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut_a (
    .ACLK       (clk),
    .ARESET     (rst),
    .axil       (ifa),
    .reg_q      (reg_q_a),
    .reg_wr_stb (stb_a)
  );

  intellight_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(3)) dut_b (
    .ACLK       (clk),
    .ARESET     (rst),
    .axil       (ifb),
    .reg_q      (reg_q_b),
    .reg_wr_stb (stb_b)
  );

  function automatic obs_t snap(input int d);
    obs_t o;
    if (d == 0) begin
      o.awready = ifa.AWREADY; o.wready = ifa.WREADY; o.bvalid = ifa.BVALID;
      o.bresp   = ifa.BRESP;   o.arready = ifa.ARREADY; o.rvalid = ifa.RVALID;
      o.rdata   = ifa.RDATA;   o.rresp  = ifa.RRESP;  o.stb = stb_a;
    end else begin
      o.awready = ifb.AWREADY; o.wready = ifb.WREADY; o.bvalid = ifb.BVALID;
      o.bresp   = ifb.BRESP;   o.arready = ifb.ARREADY; o.rvalid = ifb.RVALID;
      o.rdata   = ifb.RDATA;   o.rresp  = ifb.RRESP;  o.stb = {1'b0, stb_b};
    end
    return o;
  endfunction

  // Register i of instance d as seen on reg_q; missing registers read as zero.
  function automatic logic [31:0] regq(input int d, input int i);
    if (d == 0) return reg_q_a[i[1:0]];
    case (i)
      0:       return reg_q_b[0];
      1:       return reg_q_b[1];
      2:       return reg_q_b[2];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr) / 4;
    for (int d = 0; d < 2; d++) begin
      if (idx < nregs[d]) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) mdl[d][idx][8*b +: 8] = data[8*b +: 8];
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) mdl[d][i] = 32'h0;
  endtask

  // One full write; W leads AW by w_lead cycles, BREADY held low for b_stall cycles.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_stall);
    obs_t       o;
    logic [1:0] exp_resp [2];
    logic [3:0] exp_stb [2];
    bit         aw_done, w_done, aw_take, w_take;
    int         cyc;
    for (int d = 0; d < 2; d++) begin
      if (int'(addr) / 4 < nregs[d]) begin
        exp_resp[d] = OKAY;
        exp_stb[d]  = 4'b0001 << (int'(addr) / 4);
      end else begin
        exp_resp[d] = SLVERR;
        exp_stb[d]  = 4'b0000;
      end
    end
    wdata = data; wstrb = strb; wvalid = 1'b1; bready = (b_stall == 0);
    awaddr = addr; awvalid = (w_lead == 0);
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done)) begin
      aw_take = awvalid && ifa.AWREADY;
      w_take  = wvalid && ifa.WREADY;
      @(posedge clk); @(negedge clk);
      cyc++;
      if (aw_take) begin awvalid = 1'b0; aw_done = 1; end
      if (w_take)  begin wvalid  = 1'b0; w_done  = 1; end
      if (!aw_done && cyc == w_lead) awvalid = 1'b1;
      if (w_done && !aw_done) begin
        for (int d = 0; d < 2; d++) begin
          o = snap(d);
          n_cmp++;
          if (o.wready !== 1'b0 || o.awready !== 1'b1 || o.bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL w_only_wait dut%0d: wready=%b awready=%b bvalid=%b, expected 0 1 0", d, o.wready, o.awready, o.bvalid);
          end
        end
      end
      if (cyc > 20) begin
        n_cmp++; n_err++;
        $display("FAIL wr_handshake_timeout addr=%h: aw_done=%0d w_done=%0d, expected both after <=20 cycles", addr, aw_done, w_done);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        return;
      end
    end
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o.bvalid !== 1'b0 || o.awready !== 1'b0 || o.wready !== 1'b0 || o.stb !== 4'b0) begin
        n_err++;
        $display("FAIL wr_commit_cycle dut%0d: bvalid=%b awready=%b wready=%b stb=%b, expected 0 0 0 0000", d, o.bvalid, o.awready, o.wready, o.stb);
      end
    end
    model_write(addr, data, strb);
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o.bvalid !== 1'b1 || o.bresp !== exp_resp[d] || o.stb !== exp_stb[d]) begin
        n_err++;
        $display("FAIL wr_resp dut%0d addr=%h: bvalid=%b bresp=%b stb=%b, expected 1 %b %b", d, addr, o.bvalid, o.bresp, o.stb, exp_resp[d], exp_stb[d]);
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (regq(d, i) !== mdl[d][i]) begin
          n_err++;
          $display("FAIL reg_q dut%0d[%0d]: got %h, expected %h", d, i, regq(d, i), mdl[d][i]);
        end
      end
    end
    for (int s = 0; s < b_stall; s++) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o = snap(d);
        n_cmp++;
        if (o.bvalid !== 1'b1 || o.bresp !== exp_resp[d] || o.awready !== 1'b0 || o.wready !== 1'b0 || o.stb !== 4'b0) begin
          n_err++;
          $display("FAIL b_stall dut%0d cyc%0d: bvalid=%b bresp=%b awready=%b wready=%b stb=%b, expected 1 %b 0 0 0000", d, s, o.bvalid, o.bresp, o.awready, o.wready, o.stb, exp_resp[d]);
        end
      end
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o.bvalid !== 1'b0 || o.awready !== 1'b1 || o.wready !== 1'b1 || o.stb !== 4'b0) begin
        n_err++;
        $display("FAIL wr_done dut%0d: bvalid=%b awready=%b wready=%b stb=%b, expected 0 1 1 0000", d, o.bvalid, o.awready, o.wready, o.stb);
      end
    end
  endtask

  // One full read with RREADY held low for r_stall cycles after RVALID.
  task automatic axi_read(input logic [3:0] addr, input int r_stall);
    obs_t        o;
    logic [31:0] exp_data [2];
    logic [1:0]  exp_resp [2];
    bit          take;
    int          cyc;
    for (int d = 0; d < 2; d++) begin
      if (int'(addr) / 4 < nregs[d]) begin
        exp_data[d] = mdl[d][int'(addr) / 4];
        exp_resp[d] = OKAY;
      end else begin
        exp_data[d] = 32'h0;
        exp_resp[d] = SLVERR;
      end
    end
    araddr = addr; arvalid = 1'b1; rready = (r_stall == 0); cyc = 0;
    do begin
      take = ifa.ARREADY;
      @(posedge clk); @(negedge clk);
      cyc++;
      if (!take && cyc > 20) begin
        n_cmp++; n_err++;
        $display("FAIL rd_handshake_timeout addr=%h: no ARREADY, expected within 20 cycles", addr);
        arvalid = 1'b0; rready = 1'b1;
        return;
      end
    end while (!take);
    arvalid = 1'b0;
    for (int s = 0; s <= r_stall; s++) begin
      if (s > 0) begin @(posedge clk); @(negedge clk); end
      for (int d = 0; d < 2; d++) begin
        o = snap(d);
        n_cmp++;
        if (o.rvalid !== 1'b1 || o.rdata !== exp_data[d] || o.rresp !== exp_resp[d] || o.arready !== 1'b0) begin
          n_err++;
          $display("FAIL rd_resp dut%0d addr=%h cyc%0d: rvalid=%b rdata=%h rresp=%b arready=%b, expected 1 %h %b 0", d, addr, s, o.rvalid, o.rdata, o.rresp, o.arready, exp_data[d], exp_resp[d]);
        end
      end
    end
    rready = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o.rvalid !== 1'b0 || o.arready !== 1'b1) begin
        n_err++;
        $display("FAIL rd_done dut%0d: rvalid=%b arready=%b, expected 0 1", d, o.rvalid, o.arready);
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o !== '0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got %h, expected all zero", d, o);
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (regq(d, i) !== 32'h0) begin
          n_err++;
          $display("FAIL reset_reg_q dut%0d[%0d]: got %h, expected 0", d, i, regq(d, i));
        end
      end
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if ({o.awready, o.wready, o.arready} !== 3'b000) begin
        n_err++;
        $display("FAIL ready_before_edge dut%0d: aw/w/ar ready=%b, expected 000", d, {o.awready, o.wready, o.arready});
      end
    end
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if ({o.awready, o.wready, o.arready} !== 3'b111 || o.bvalid !== 1'b0 || o.rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL ready_after_edge dut%0d: aw/w/ar ready=%b bvalid=%b rvalid=%b, expected 111 0 0", d, {o.awready, o.wready, o.arready}, o.bvalid, o.rvalid);
      end
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
  endtask

  task automatic test_strobes();
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(4'h4, 32'h0000_0000, 4'b0101, 0, 0);
    n_cmp++;
    if (reg_q_a[1] !== 32'hFF00_FF00) begin
      n_err++;
      $display("FAIL partial_strobe: reg1=%h, expected ff00ff00", reg_q_a[1]);
    end
    axi_read(4'h4, 0);
    axi_write(4'h8, $urandom, 4'b0000, 0, 0);
    axi_read(4'h8, 0);
  endtask

  task automatic test_w_first();
    axi_write(4'h0, $urandom, 4'hF, 3, 0);
    axi_write(4'hE, $urandom, 4'hF, 2, 1);
    axi_read(4'h1, 0);
  endtask

  task automatic test_backpressure();
    axi_write(4'h4, 32'hCAFE_F00D, 4'hF, 0, 5);
    axi_read(4'h4, 5);
    axi_write(4'hC, 32'h1357_9BDF, 4'hF, 1, 5);
    axi_read(4'hC, 5);
  endtask

  // AR lands on the same edge that commits a write to the same register.
  task automatic test_read_during_commit();
    obs_t        o;
    logic [31:0] old_val [2];
    logic [31:0] new_val;
    new_val = $urandom;
    for (int d = 0; d < 2; d++) old_val[d] = mdl[d][1];
    awaddr = 4'h4; wdata = new_val; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o.rvalid !== 1'b1 || o.rdata !== old_val[d] || o.bvalid !== 1'b1) begin
        n_err++;
        $display("FAIL read_vs_commit dut%0d: rvalid=%b rdata=%h bvalid=%b, expected 1 %h 1", d, o.rvalid, o.rdata, o.bvalid, old_val[d]);
      end
    end
    model_write(4'h4, new_val, 4'hF);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o.rvalid !== 1'b0 || o.bvalid !== 1'b0) begin
        n_err++;
        $display("FAIL read_vs_commit_done dut%0d: rvalid=%b bvalid=%b, expected 0 0", d, o.rvalid, o.bvalid);
      end
    end
    axi_read(4'h4, 0);
  endtask

  task automatic test_random();
    logic [3:0]  a;
    logic [31:0] v;
    logic [3:0]  s;
    repeat (24) begin
      a = 4'($urandom_range(0, 15));
      v = $urandom;
      s = 4'($urandom_range(0, 15));
      axi_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 2));
      axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_abort();
    obs_t        o;
    logic [31:0] pre [2];
    for (int d = 0; d < 2; d++) pre[d] = mdl[d][2];
    awaddr = 4'h8; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o.bvalid !== 1'b1 || o.rvalid !== 1'b1 || o.rdata !== pre[d]) begin
        n_err++;
        $display("FAIL abort_setup dut%0d: bvalid=%b rvalid=%b rdata=%h, expected 1 1 %h", d, o.bvalid, o.rvalid, o.rdata, pre[d]);
      end
    end
    rst = 1'b1;
    #1;
    model_clear();
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o !== '0) begin
        n_err++;
        $display("FAIL abort_outputs dut%0d: got %h, expected all zero", d, o);
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (regq(d, i) !== 32'h0) begin
          n_err++;
          $display("FAIL abort_reg_q dut%0d[%0d]: got %h, expected 0", d, i, regq(d, i));
        end
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; bready = 1'b1; rready = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      n_cmp++;
      if (o.bvalid !== 1'b0 || o.rvalid !== 1'b0 || {o.awready, o.wready, o.arready} !== 3'b111) begin
        n_err++;
        $display("FAIL abort_release dut%0d: bvalid=%b rvalid=%b readies=%b, expected 0 0 111", d, o.bvalid, o.rvalid, {o.awready, o.wready, o.arready});
      end
    end
    axi_write(4'h8, 32'h0000_00A5, 4'hF, 0, 0);
    axi_read(4'h8, 0);
    n_cmp++;
    if (reg_q_a[2] !== 32'h0000_00A5) begin
      n_err++;
      $display("FAIL abort_rewrite: reg2=%h, expected 000000a5", reg_q_a[2]);
    end
  endtask

  initial begin
    nregs[0] = 4;
    nregs[1] = 3;
    model_clear();
    test_reset();
    test_sequential();
    test_strobes();
    test_w_first();
    test_backpressure();
    test_read_during_commit();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at 500000 ns, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/intellight_axil_regs.md
# intellight_axil_regs

AXI4-Lite slave register file, the responder side of the accelerator's control bus. It sits between the PS/VIP AXI4-Lite master and the Intellight accelerator core. It accepts single-beat reads and writes to NUM_REGS 32-bit control registers, drives the register contents to the core, and pulses a per-register strobe on every committed write.

## Interface
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI byte-address width.
- NUM_REGS, 4, number of implemented registers; must be ≤ 2^(ADDR_WIDTH-2).
- ACLK  in  1  clock; all logic on its rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write address. AWPROT  in  3  ignored. AWVALID  in  1. AWREADY  out  1.
- WDATA  in  32. WSTRB  in  4  byte enables. WVALID  in  1. WREADY  out  1.
- BRESP  out  2. BVALID  out  1. BREADY  in  1.
- ARADDR  in  ADDR_WIDTH. ARPROT  in  3  ignored. ARVALID  in  1. ARREADY  out  1.
- RDATA  out  32. RRESP  out  2. RVALID  out  1. RREADY  in  1.
- reg_q  out  NUM_REGS×32  current register contents, to the core.
- reg_wr_stb  out  NUM_REGS  one-cycle pulse per register on a committed write.

## Operation
- Register index is ADDR[ADDR_WIDTH-1:2]. ADDR[1:0] is ignored.
- An index ≥ NUM_REGS is out of range:
  - writes are dropped, no strobe, BRESP=SLVERR (2'b10);
  - reads return RDATA=0 with RRESP=SLVERR.
- In-range accesses respond OKAY (2'b00).
- Write FSM states: WR_IDLE, WR_COMMIT, WR_RESP.
  - WR_IDLE: AWREADY=1 until an address is latched; WREADY=1 until data+strobe are latched. AW and W are accepted independently, in either order or in the same cycle.
  - Both latched: go to WR_COMMIT. AWREADY and WREADY are low from here until return to WR_IDLE.
  - WR_COMMIT (one cycle): apply the write byte-wise per WSTRB, pulse reg_wr_stb[idx], load BRESP, set BVALID, go to WR_RESP.
  - WR_RESP: hold BVALID and BRESP until BREADY=1, then clear BVALID and go to WR_IDLE.
  - At most one write is outstanding.
- WSTRB=4'b0000 to an in-range register: OKAY response, contents unchanged, strobe still pulses.
- Read FSM states: RD_IDLE, RD_RESP.
  - RD_IDLE: ARREADY=1. On the AR handshake, register RDATA/RRESP from the addressed register and set RVALID.
  - RD_RESP: ARREADY=0; hold RDATA/RRESP/RVALID stable until RREADY=1, then go to RD_IDLE.
- Read and write channels are fully concurrent. If an AR handshake and a WR_COMMIT hit the same register on the same edge, the read returns the pre-write value.

## Timing
- Reset values: all registers 0; AWREADY=WREADY=ARREADY=0 while ARESET=1, then 1 from the first edge after release. BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, reg_wr_stb=0.
- Write latency: last of the AW/W handshakes at edge N → register updated and BVALID=1 after edge N+1. reg_wr_stb is high for the cycle between edges N+1 and N+2.
- Read latency: AR handshake at edge N → RVALID=1 and RDATA valid after edge N.
- With BREADY and RREADY tied high, write throughput is one per 3 cycles and read throughput is one per 2 cycles.
- Reset asserted mid-transaction: aborts immediately, FSMs return to IDLE, registers clear, and no response is issued for the aborted transaction.
- Valid/ready rules follow AXI: no output VALID depends combinationally on an input READY; RDATA/BRESP are stable while VALID is high and READY is low.

## Structure
- Package intellight_axil_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the wr_state_t enum (WR_IDLE/WR_COMMIT/WR_RESP) and the rd_state_t enum (RD_IDLE/RD_RESP);
  - an idx_in_range function.
- The module is flat. Both FSMs and the register array live in intellight_axil_regs with no sub-modules.

## Test plan
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then reads of the same addresses → RDATA 1, 2, 3, 4; every BRESP and RRESP OKAY; reg_q matches; each reg_wr_stb pulses once.
- Write 0xFFFFFFFF to 0x4, then write 0x00000000 with WSTRB=4'b0101 → reading 0x4 returns 0xFF00FF00.
- Present W three cycles before AW, then AW alone → WREADY drops after the W handshake; the write commits after AW; BVALID follows one edge later.
- Hold BREADY low for 5 cycles → BVALID and BRESP stay stable, AWREADY and WREADY stay low, and a new AW is not accepted until the B handshake. Repeat with RREADY low on a read → RDATA held.
- With NUM_REGS=3, write and read 0xC → BRESP=SLVERR, RDATA=0, RRESP=SLVERR, no strobe, reg_q unchanged.
- Assert ARESET while in WR_RESP and RD_RESP → BVALID=RVALID=0 and reg_q all 0 immediately; after release the write 0x8=0xA5 / read 0x8 sequence returns 0xA5.
